// File: rtl/rx_sync_ctrl_pkg.sv
// Shared types and constants for the receive symbol-lock controller.
// Also holds the K28.5 code words used by the comma detector.
package rx_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    RX_HUNT    = 2'd0,
    RX_CONFIRM = 2'd1,
    RX_LOCKED  = 2'd2
  } rxState_t;

  localparam int unsigned SYMBOL_BITS = 10;
  localparam logic [SYMBOL_BITS-1:0] K285_NEG = 10'b0011111010;
  localparam logic [SYMBOL_BITS-1:0] K285_POS = 10'b1100000101;

  // Counter width for a count that must reach n-1; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] nextOffset(input logic [3:0] cur);
    return (32'(cur) >= SYMBOL_BITS - 1) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/rx_err_monitor.sv
// Net decode-error tracker used while locked: errors count up, each run of
// GOOD_RUN clean symbols forgives one error.
module rx_err_monitor
  import rx_sync_ctrl_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned GOOD_RUN  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       sym_event,
  input  logic       is_err,
  output logic [2:0] err_cnt,
  output logic       limit_hit
);

  localparam int unsigned ErrW  = cntWidth(ERR_LIMIT);
  localparam int unsigned GoodW = cntWidth(GOOD_RUN);
  localparam logic [ErrW-1:0]  ErrLast  = ErrW'(ERR_LIMIT - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(GOOD_RUN - 1);

  logic [ErrW-1:0]  errQ;
  logic [GoodW-1:0] goodQ;

  // Combinational so the FSM can drop lock on the same edge as the final error.
  assign limit_hit = is_err && (errQ == ErrLast);
  assign err_cnt   = 3'(errQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errQ  <= '0;
      goodQ <= '0;
    end else if (clear) begin
      errQ  <= '0;
      goodQ <= '0;
    end else if (sym_event) begin
      if (is_err) begin
        goodQ <= '0;
        errQ  <= limit_hit ? '0 : errQ + 1'b1;
      end else if (goodQ == GoodLast) begin
        goodQ <= '0;
        if (errQ != '0) errQ <= errQ - 1'b1;
      end else begin
        goodQ <= goodQ + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Symbol-lock controller: hunts for K28.5 alignment by slipping the bit
// boundary, confirms it, and drops lock after an error burst.
module rx_sync_ctrl
  import rx_sync_ctrl_pkg::*;
#(
  parameter int unsigned COMMA_CONFIRM = 3,
  parameter int unsigned HUNT_TIMEOUT  = 16,
  parameter int unsigned ERR_LIMIT     = 4,
  parameter int unsigned GOOD_RUN      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       sym_valid,
  input  logic       is_k285,
  input  logic       dec_error,
  output logic       slip,
  output logic [3:0] offset,
  output logic       rx_valid,
  output logic [1:0] state,
  output logic [2:0] err_cnt,
  output logic       lock_lost
);

  localparam int unsigned HuntW  = cntWidth(HUNT_TIMEOUT);
  localparam int unsigned CommaW = cntWidth(COMMA_CONFIRM);
  localparam logic [HuntW-1:0]  HuntLast  = HuntW'(HUNT_TIMEOUT - 1);
  localparam logic [CommaW-1:0] CommaLast = CommaW'(COMMA_CONFIRM - 1);

  rxState_t          stateQ;
  logic [3:0]        offsetQ;
  logic [HuntW-1:0]  huntQ;
  logic [HuntW-1:0]  winQ;
  logic [CommaW-1:0] commaQ;
  logic              slipQ;
  logic              rxValidQ;
  logic              lockLostQ;

  logic symEvt;
  logic isComma;
  logic lockEntry;
  logic lockedEvt;
  logic limitHit;

  assign symEvt    = enb & sym_valid;
  assign isComma   = is_k285 & ~dec_error;
  assign lockEntry = symEvt && (stateQ == RX_CONFIRM) && isComma && (commaQ == CommaLast);
  assign lockedEvt = symEvt && (stateQ == RX_LOCKED);

  rx_err_monitor #(
    .ERR_LIMIT(ERR_LIMIT),
    .GOOD_RUN (GOOD_RUN)
  ) u_errMon (
    .clk      (clk),
    .rst      (rst),
    .clear    (lockEntry),
    .sym_event(lockedEvt),
    .is_err   (dec_error),
    .err_cnt  (err_cnt),
    .limit_hit(limitHit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= RX_HUNT;
      offsetQ   <= '0;
      huntQ     <= '0;
      winQ      <= '0;
      commaQ    <= '0;
      slipQ     <= 1'b0;
      rxValidQ  <= 1'b0;
      lockLostQ <= 1'b0;
    end else begin
      slipQ     <= 1'b0;
      lockLostQ <= 1'b0;
      if (symEvt) begin
        unique case (stateQ)
          RX_HUNT: begin
            if (isComma) begin
              stateQ <= RX_CONFIRM;
              commaQ <= CommaW'(1);
              winQ   <= '0;
              huntQ  <= '0;
            end else if (huntQ == HuntLast) begin
              slipQ   <= 1'b1;
              offsetQ <= nextOffset(offsetQ);
              huntQ   <= '0;
            end else begin
              huntQ <= huntQ + 1'b1;
            end
          end
          RX_CONFIRM: begin
            if (dec_error) begin
              stateQ <= RX_HUNT;
              huntQ  <= '0;
            end else if (isComma) begin
              winQ <= '0;
              if (commaQ == CommaLast) begin
                stateQ   <= RX_LOCKED;
                rxValidQ <= 1'b1;
              end else begin
                commaQ <= commaQ + 1'b1;
              end
            end else if (winQ == HuntLast) begin
              stateQ <= RX_HUNT;
              huntQ  <= '0;
            end else begin
              winQ <= winQ + 1'b1;
            end
          end
          RX_LOCKED: begin
            // Offset is kept on loss of lock so re-hunting starts from the last good boundary.
            if (limitHit) begin
              stateQ    <= RX_HUNT;
              rxValidQ  <= 1'b0;
              lockLostQ <= 1'b1;
              huntQ     <= '0;
            end
          end
          default: begin
            stateQ   <= RX_HUNT;
            rxValidQ <= 1'b0;
            huntQ    <= '0;
          end
        endcase
      end
    end
  end

  assign slip      = slipQ;
  assign offset    = offsetQ;
  assign rx_valid  = rxValidQ;
  assign state     = stateQ;
  assign lock_lost = lockLostQ;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Scoreboard bench for rx_sync_ctrl: stimulus pushes model predictions,
// a monitor pops and compares on every sampled symbol event.
module tb_rx_sync_ctrl;

  localparam int CC = 3;
  localparam int HT = 16;
  localparam int EL = 4;
  localparam int GR = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       sym_valid = 1'b0;
  logic       is_k285 = 1'b0;
  logic       dec_error = 1'b0;
  logic       slip;
  logic [3:0] offset;
  logic       rx_valid;
  logic [1:0] state;
  logic [2:0] err_cnt;
  logic       lock_lost;

  rx_sync_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .sym_valid(sym_valid),
    .is_k285  (is_k285),
    .dec_error(dec_error),
    .slip     (slip),
    .offset   (offset),
    .rx_valid (rx_valid),
    .state    (state),
    .err_cnt  (err_cnt),
    .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int slipSeen = 0;
  logic [11:0] expQ[$];

  // Reference model: plain integer counters following the symbol rules.
  int mState, mOff, mHunt, mComma, mWin, mErr, mGood;

  function automatic void modelReset();
    mState = 0; mOff = 0; mHunt = 0; mComma = 0; mWin = 0; mErr = 0; mGood = 0;
  endfunction

  function automatic void modelStep(input bit k, input bit e, output logic [11:0] ex);
    bit comma, sl, lost;
    comma = k && !e;
    sl = 0;
    lost = 0;
    if (mState == 0) begin
      if (comma) begin
        mState = 1; mComma = 1; mWin = 0;
      end else begin
        mHunt++;
        if (mHunt == HT) begin
          sl = 1; mOff = (mOff + 1) % 10; mHunt = 0;
        end
      end
    end else if (mState == 1) begin
      if (e) begin
        mState = 0; mHunt = 0;
      end else if (comma) begin
        mComma++; mWin = 0;
        if (mComma == CC) begin
          mState = 2; mErr = 0; mGood = 0;
        end
      end else begin
        mWin++;
        if (mWin == HT) begin
          mState = 0; mHunt = 0;
        end
      end
    end else begin
      if (e) begin
        mGood = 0; mErr++;
        if (mErr == EL) begin
          mState = 0; lost = 1; mErr = 0; mHunt = 0;
        end
      end else begin
        mGood++;
        if (mGood == GR) begin
          mGood = 0;
          if (mErr > 0) mErr--;
        end
      end
    end
    ex = {2'(mState), 4'(mOff), (mState == 2), 3'(mErr), sl, lost};
  endfunction

  function automatic void check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (state,offset,rx_valid,err_cnt,slip,lock_lost)",
               nm, act, exp);
    end
  endfunction

  wire [11:0] outs = {state, offset, rx_valid, err_cnt, slip, lock_lost};

  always @(posedge clk) begin
    bit evt;
    evt = enb && sym_valid && !rst;
    #1;
    if (slip) slipSeen++;
    if (evt) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL sb_underflow: got output %h expected no event", outs);
      end else begin
        check("symbol", outs, expQ.pop_front());
      end
    end else begin
      check("idle_pulses", {10'd0, slip, lock_lost}, 12'd0);
    end
  end

  task automatic sendSym(input bit k, input bit e, input bit en, input int gap);
    logic [11:0] ex;
    @(negedge clk);
    enb = en; sym_valid = 1'b1; is_k285 = k; dec_error = e;
    if (en) begin
      modelStep(k, e, ex);
      expQ.push_back(ex);
    end
    @(negedge clk);
    sym_valid = 1'b0; is_k285 = 1'($urandom); dec_error = 1'($urandom); enb = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; sym_valid = 1'b0;
    #1 check("reset_values", outs, 12'd0);
    expQ.delete();
    modelReset();
    @(negedge clk);
    rst = 1'b0; enb = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic rstNow(input string nm);
    #1 rst = 1'b1;
    #1 check(nm, outs, 12'd0);
    expQ.delete();
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lockUp();
    repeat (CC) sendSym(1, 0, 1, 8);
  endtask

  initial begin
    int r;
    bit k, e;
    modelReset();
    doReset();

    // Three aligned commas lock the link.
    slipSeen = 0;
    lockUp();
    check("lock_slips", 12'(slipSeen), 12'd0);

    // 160 data symbols in HUNT: ten slips, offset wraps to 0.
    doReset();
    slipSeen = 0;
    repeat (160) sendSym(0, 0, 1, 0);
    check("hunt_slips", 12'(slipSeen), 12'd10);
    check("hunt_wrap", {8'd0, offset}, 12'(mOff));

    // CONFIRM aborted by an error, then hunt counter restarts from zero.
    doReset();
    sendSym(1, 0, 1, 0);
    sendSym(0, 0, 1, 0);
    sendSym(0, 1, 1, 0);
    repeat (HT) sendSym(0, 0, 1, 0);

    // Four errors among good symbols drop lock; reset kills the lock_lost pulse.
    doReset();
    repeat (3) sendSym(0, 0, 1, 0);
    lockUp();
    sendSym(0, 1, 1, 0); sendSym(0, 0, 1, 0); sendSym(1, 1, 1, 0);
    sendSym(0, 0, 1, 0); sendSym(0, 0, 1, 0); sendSym(0, 1, 1, 0);
    sendSym(1, 0, 1, 0); sendSym(0, 1, 1, 0);
    check("lost_offset", {8'd0, offset}, 12'(mOff));
    rstNow("rst_kills_lock_lost");

    // Error / 16 good / error / 16 good keeps lock.
    doReset();
    lockUp();
    repeat (2) begin
      sendSym(0, 1, 1, 0);
      repeat (GR) sendSym(($urandom_range(0, 3) == 0), 0, 1, 0);
    end
    check("forgive_hold", {10'd0, state}, 12'd2);

    // K28.5 with decode error is not a comma; enb=0 strobes are ignored.
    doReset();
    repeat (3) sendSym(1, 1, 1, 0);
    repeat (5) sendSym(1, 0, 0, 0);
    repeat (13) sendSym(0, 0, 1, 0);

    // Asynchronous reset mid-CONFIRM.
    sendSym(1, 0, 1, 0);
    sendSym(1, 0, 1, 0);
    rstNow("rst_mid_confirm");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      k = (r < 40) || (r >= 88 && r < 93);
      e = (r >= 88);
      sendSym(k, e, ($urandom_range(0, 9) != 0), $urandom_range(0, 2));
      if (i == 750) rstNow("rst_random");
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 12'(expQ.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
